// File: rtl/div.sv
// div: multi-cycle 32-bit restoring divider for MIPS DIV/DIVU.
// Ports: clk, rst (sync active-high); start/annul request and abort;
// signed_div, opdata1 (dividend), opdata2 (divisor) are sampled with start;
// result = {remainder, quotient} and ready are registered outputs.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        annul,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic [63:0] result,
  output logic        ready
);
  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;
  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [32:0] r_rem;
  logic [31:0] r_q;
  logic [31:0] r_divisor;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        w_neg1;
  logic        w_neg2;
  logic [32:0] w_trial;
  logic        w_ge;
  logic [31:0] w_quo;
  logic [31:0] w_remv;
  assign w_neg1  = signed_div & opdata1[31];
  assign w_neg2  = signed_div & opdata2[31];
  // r_q starts as the dividend magnitude and shifts quotient bits in at the LSB
  assign w_trial = {r_rem[31:0], r_q[31]};
  assign w_ge    = w_trial >= {1'b0, r_divisor};
  assign w_quo   = r_neg_q ? -r_q : r_q;
  assign w_remv  = r_neg_r ? -r_rem[31:0] : r_rem[31:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      result  <= '0;
      ready   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start && !annul) begin
          if (opdata2 == 32'd0) r_state <= DIVZERO;
          else begin
            r_q       <= w_neg1 ? -opdata1 : opdata1;
            r_divisor <= w_neg2 ? -opdata2 : opdata2;
            r_neg_q   <= w_neg1 ^ w_neg2;
            r_neg_r   <= w_neg1;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_state   <= ON;
          end
        end
        DIVZERO: if (annul) r_state <= IDLE;
        else begin
          result  <= '0;
          ready   <= 1'b1;
          r_state <= END;
        end
        ON: if (annul) begin
          result  <= '0;
          ready   <= 1'b0;
          r_state <= IDLE;
        end else if (r_cnt == 6'd32) begin
          result  <= {w_remv, w_quo};
          ready   <= 1'b1;
          r_state <= END;
        end else begin
          r_rem <= w_ge ? w_trial - {1'b0, r_divisor} : w_trial;
          r_q   <= {r_q[30:0], w_ge};
          r_cnt <= r_cnt + 6'd1;
        end
        END: if (!start || annul) begin
          result  <= '0;
          ready   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
